// File: rtl/instruction_decode_queue.sv
// Dual-stream instruction decoder: local and global words are decoded on entry
// and queued as field records in independent DEPTH-entry FIFOs with valid/ready.

module idq_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] hold;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready comes from the registered count only, so a full FIFO refuses a
    // push even when the head is popped in the same cycle.
    assign push_ready = (count < CW'(DEPTH));
    assign pop_valid  = (count != '0);
    assign do_push    = push_valid & push_ready & ~flush;
    assign do_pop     = pop_valid & pop_ready & ~flush;

    // NOTE: non-blocking assignments everywhere in clocked state so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
                hold   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and the empty-state outputs come from hold.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // When empty the outputs keep showing the last entry that left the FIFO.
    assign head_data = pop_valid ? mem[rd_ptr] : hold;

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

endmodule

module instruction_decode_queue #(
    parameter int INST_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 4,
    parameter int REG_WIDTH    = 4,
    parameter int DEPTH        = 2,
    parameter logic [(2**OPCODE_WIDTH)-1:0] VALID_OPCODE_MASK = '1,
    localparam int IMM_S = INST_WIDTH - OPCODE_WIDTH - 2 * REG_WIDTH,
    localparam int IMM_L = INST_WIDTH - OPCODE_WIDTH - REG_WIDTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    // local stream
    input  logic                    inst_valid,
    input  logic [INST_WIDTH-1:0]   instruction,
    output logic                    inst_ready,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [REG_WIDTH-1:0]    target_reg,
    output logic [REG_WIDTH-1:0]    address_reg,
    output logic [IMM_S-1:0]        imm_short,
    output logic [1:0]              array_id,
    output logic                    illegal_op,
    output logic [CW-1:0]           local_count,
    // global stream
    input  logic                    global_valid,
    input  logic [INST_WIDTH-1:0]   global_instruction,
    output logic                    global_ready,
    output logic                    gdec_valid,
    input  logic                    gdec_ready,
    output logic [OPCODE_WIDTH-1:0] global_opcode,
    output logic [REG_WIDTH-1:0]    global_reg,
    output logic [IMM_L-1:0]        imm_long,
    output logic                    global_illegal_op,
    output logic [CW-1:0]           global_count
);

    if (IMM_S < 2) begin : g_bad_imm_short
        $error("instruction_decode_queue: imm_short must be at least 2 bits wide");
    end
    if (IMM_L < 1) begin : g_bad_imm_long
        $error("instruction_decode_queue: imm_long must be at least 1 bit wide");
    end

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [REG_WIDTH-1:0]    target_reg;
        logic [REG_WIDTH-1:0]    address_reg;
        logic [IMM_S-1:0]        imm_short;
        logic                    illegal;
    } local_fields_t;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [REG_WIDTH-1:0]    reg_idx;
        logic [IMM_L-1:0]        imm_long;
        logic                    illegal;
    } global_fields_t;

    local_fields_t  l_in;
    local_fields_t  l_head;
    global_fields_t g_in;
    global_fields_t g_head;

    // Decode happens before storage, so the queues hold ready-to-use fields.
    always_comb begin
        l_in             = '0;
        l_in.opcode      = instruction[INST_WIDTH-1 -: OPCODE_WIDTH];
        l_in.target_reg  = instruction[IMM_S+REG_WIDTH +: REG_WIDTH];
        l_in.address_reg = instruction[IMM_S +: REG_WIDTH];
        l_in.imm_short   = instruction[IMM_S-1:0];
        l_in.illegal     = ~VALID_OPCODE_MASK[l_in.opcode];

        g_in          = '0;
        g_in.opcode   = global_instruction[INST_WIDTH-1 -: OPCODE_WIDTH];
        g_in.reg_idx  = global_instruction[IMM_L +: REG_WIDTH];
        g_in.imm_long = global_instruction[IMM_L-1:0];
        g_in.illegal  = ~VALID_OPCODE_MASK[g_in.opcode];
    end

    idq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(local_fields_t))
    ) u_local_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (inst_valid),
        .push_data  (l_in),
        .push_ready (inst_ready),
        .pop_valid  (dec_valid),
        .pop_ready  (dec_ready),
        .head_data  (l_head),
        .count      (local_count)
    );

    idq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(global_fields_t))
    ) u_global_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (global_valid),
        .push_data  (g_in),
        .push_ready (global_ready),
        .pop_valid  (gdec_valid),
        .pop_ready  (gdec_ready),
        .head_data  (g_head),
        .count      (global_count)
    );

    assign opcode      = l_head.opcode;
    assign target_reg  = l_head.target_reg;
    assign address_reg = l_head.address_reg;
    assign imm_short   = l_head.imm_short;
    assign array_id    = l_head.imm_short[IMM_S-1 -: 2];
    // The stored flag of a departed entry must not leak out while empty.
    assign illegal_op  = dec_valid & l_head.illegal;

    assign global_opcode     = g_head.opcode;
    assign global_reg        = g_head.reg_idx;
    assign imm_long          = g_head.imm_long;
    assign global_illegal_op = gdec_valid & g_head.illegal;

endmodule

// File: doc/instruction_decode_queue.md
Name: instruction_decode_queue

Overview:
Registered, parametrised decoder for the compute unit's two instruction streams: local (per-warp) and global (control). Each stream has its own valid/ready input handshake and a DEPTH-entry FIFO of decoded fields. The local stream feeds the instruction buffer; the global stream feeds control. Adds generalised field widths, back-pressure, an illegal-opcode flag, occupancy reporting and flush.

Parameters:
INST_WIDTH, 16, instruction word width in bits
OPCODE_WIDTH, 4, opcode field width (MSBs)
REG_WIDTH, 4, register-index field width
DEPTH, 2, entries per stream FIFO (>=1)
VALID_OPCODE_MASK, {2**OPCODE_WIDTH{1'b1}}, bit n set = opcode n legal

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of both FIFOs
inst_valid  in  1  local instruction offered
instruction  in  INST_WIDTH  local instruction word
inst_ready  out  1  local FIFO can accept
dec_valid  out  1  head of local FIFO valid
dec_ready  in  1  consumer pops local head
opcode  out  OPCODE_WIDTH  instruction[INST_WIDTH-1 -: OPCODE_WIDTH]
target_reg  out  REG_WIDTH  next REG_WIDTH bits below opcode
address_reg  out  REG_WIDTH  next REG_WIDTH bits below target_reg
imm_short  out  IMM_S=INST_WIDTH-OPCODE_WIDTH-2*REG_WIDTH  remaining LSBs; also warp mask
array_id  out  2  imm_short[IMM_S-1 -: 2]
illegal_op  out  1  VALID_OPCODE_MASK[opcode]==0 for local head
local_count  out  $clog2(DEPTH+1)  local occupancy
global_valid  in  1  global instruction offered
global_instruction  in  INST_WIDTH  global instruction word
global_ready  out  1  global FIFO can accept
gdec_valid  out  1  head of global FIFO valid
gdec_ready  in  1  control pops global head
global_opcode  out  OPCODE_WIDTH  MSB opcode field
global_reg  out  REG_WIDTH  next REG_WIDTH bits
imm_long  out  INST_WIDTH-OPCODE_WIDTH-REG_WIDTH  remaining LSBs
global_illegal_op  out  1  mask check on global head
global_count  out  $clog2(DEPTH+1)  global occupancy

Behaviour:
- Reset (rst_n low, async): both FIFOs empty, pointers/counts 0. dec_valid=gdec_valid=0; inst_ready=global_ready=1; all field outputs and illegal flags 0. Release takes effect on next clk edge.
- Elaboration: IMM_S>=2 and imm_long width>=1 required; otherwise $error.
- Push: accepted when valid&&ready at clk edge. Fields are decoded and stored with the entry (FIFO holds decoded fields, not raw words).
- Latency: accepted word visible at outputs with *_valid=1 the cycle after acceptance if FIFO was empty. No combinational input-to-output path.
- Pop: when *_valid&&*_ready at clk edge, head advances. Outputs always reflect head entry. When empty, fields hold last popped values; flags are 0.
- ready = (count < DEPTH), registered-count based. A full FIFO stays not-ready even if popping the same cycle. No bypass.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Count never exceeds DEPTH and never underflows. A pop while empty is ignored.
- flush: at the clk edge, both FIFOs are emptied. A push or pop the same cycle is discarded (flush dominates). *_valid=0 next cycle.
- Streams are fully independent: no ordering relation between local and global entries.
- illegal_op is informational only. Illegal words are queued and popped like any other.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
- Reset then push instruction=16'h3A5C -> next cycle dec_valid=1, opcode=3, target_reg=A, address_reg=5, imm_short=C, array_id=3, illegal_op=0, local_count=1.
- Push global_instruction=16'h9F42 with gdec_ready=0 -> gdec_valid=1, global_opcode=9, global_reg=F, imm_long=8'h42; holds stable until gdec_ready=1, then gdec_valid=0.
- DEPTH=2, dec_ready=0, push 16'h1111, 16'h2222, 16'h3333 -> third not accepted (inst_ready=0, count=2). Pops return 1111 then 2222 in order.
- DEPTH=3, continuous push and pop of 10 words 16'h0000..16'h9000 -> pointer wrap, opcodes 0..9 in order, count steady at 1.
- VALID_OPCODE_MASK=16'h00FF, push 16'hA000 -> illegal_op=1. Push 16'h7000 -> illegal_op=0 when it reaches the head.
- Fill both FIFOs, assert flush together with inst_valid -> next cycle both counts=0, valid=0, pushed word dropped. Separately, assert rst_n=0 between edges -> outputs clear immediately.
